// File: rtl/alu_pkg.sv
// Shared constants for the ALU command sequencer: opcodes, one-hot select
// encodings and the sequencer FSM state type.
package alu_pkg;

  localparam logic [2:0] OP_AND   = 3'd0;
  localparam logic [2:0] OP_OR    = 3'd1;
  localparam logic [2:0] OP_NOT   = 3'd2;
  localparam logic [2:0] OP_XOR   = 3'd3;
  localparam logic [2:0] OP_ADD   = 3'd4;
  localparam logic [2:0] OP_SUB   = 3'd5;
  localparam logic [2:0] OP_MULT  = 3'd6;
  localparam logic [2:0] OP_CLEAR = 3'd7;

  localparam logic [2:0] IN_SEL_PERSIST = 3'b100;
  localparam logic [2:0] IN_SEL_LOAD    = 3'b010;
  localparam logic [2:0] IN_SEL_RESET   = 3'b001;

  localparam logic [6:0] OUT_SEL_AND  = 7'b1000000;
  localparam logic [6:0] OUT_SEL_OR   = 7'b0100000;
  localparam logic [6:0] OUT_SEL_NOT  = 7'b0010000;
  localparam logic [6:0] OUT_SEL_XOR  = 7'b0001000;
  localparam logic [6:0] OUT_SEL_ADD  = 7'b0000100;
  localparam logic [6:0] OUT_SEL_SUB  = 7'b0000010;
  localparam logic [6:0] OUT_SEL_MULT = 7'b0000001;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } seq_state_e;

endpackage

// File: rtl/alu_op_decode.sv
// Combinational opcode decoder: opcode to one-hot ALU output select, plus a
// flag marking the CLEAR opcode.
module alu_op_decode
  import alu_pkg::*;
(
  input  logic [2:0] op_i,
  output logic [6:0] out_sel_o,
  output logic       is_clear_o
);

  // CLEAR has no ALU operation of its own; it parks on AND, the reset select.
  always_comb begin
    out_sel_o  = OUT_SEL_AND;
    is_clear_o = 1'b0;
    case (op_i)
      OP_AND:   out_sel_o = OUT_SEL_AND;
      OP_OR:    out_sel_o = OUT_SEL_OR;
      OP_NOT:   out_sel_o = OUT_SEL_NOT;
      OP_XOR:   out_sel_o = OUT_SEL_XOR;
      OP_ADD:   out_sel_o = OUT_SEL_ADD;
      OP_SUB:   out_sel_o = OUT_SEL_SUB;
      OP_MULT:  out_sel_o = OUT_SEL_MULT;
      OP_CLEAR: is_clear_o = 1'b1;
      default:  out_sel_o = OUT_SEL_AND;
    endcase
  end

endmodule

// File: rtl/alu_cmd_sequencer.sv
// Host-side ALU driver: one command in flight, registered ALU lines, result
// capture after ALU_LATENCY cycles. Chained operands are enabled by ALU_SEQ_CHAIN_EN.
module alu_cmd_sequencer
  import alu_pkg::*;
#(
  parameter int ALU_LATENCY = 1,
  parameter int WIDTH       = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_a,
  input  logic [WIDTH-1:0] cmd_b,
  input  logic             cmd_chain,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_data,
  output logic             rsp_ovf,
  output logic             rsp_err,
  output logic [2:0]       alu_in_sel,
  output logic [WIDTH-1:0] alu_num1,
  output logic [WIDTH-1:0] alu_num2,
  output logic [6:0]       alu_out_sel,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_ovf
);

  seq_state_e       state_q, state_d;
  logic             clr_q, clr_d;
  logic             chain_q, chain_d;
  logic [2:0]       cnt_q, cnt_d;
  logic             have_result_q, have_result_d;
  logic [WIDTH-1:0] rsp_data_q, rsp_data_d;
  logic             rsp_ovf_q, rsp_ovf_d;
  logic             rsp_err_q, rsp_err_d;
  logic [2:0]       in_sel_q, in_sel_d;
  logic [WIDTH-1:0] num1_q, num1_d;
  logic [WIDTH-1:0] num2_q, num2_d;
  logic [6:0]       out_sel_q, out_sel_d;

  logic [6:0]       dec_out_sel;
  logic             dec_is_clear;
  logic             chain_req;

  alu_op_decode u_decode (
    .op_i       (cmd_op),
    .out_sel_o  (dec_out_sel),
    .is_clear_o (dec_is_clear)
  );

`ifdef ALU_SEQ_CHAIN_EN
  assign chain_req = cmd_chain;
`else
  logic unused_chain;
  assign unused_chain = cmd_chain;
  assign chain_req    = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      clr_q         <= 1'b0;
      chain_q       <= 1'b0;
      cnt_q         <= 3'd0;
      have_result_q <= 1'b0;
      rsp_data_q    <= '0;
      rsp_ovf_q     <= 1'b0;
      rsp_err_q     <= 1'b0;
      in_sel_q      <= IN_SEL_RESET;
      num1_q        <= '0;
      num2_q        <= '0;
      out_sel_q     <= OUT_SEL_AND;
    end else begin
      state_q       <= state_d;
      clr_q         <= clr_d;
      chain_q       <= chain_d;
      cnt_q         <= cnt_d;
      have_result_q <= have_result_d;
      rsp_data_q    <= rsp_data_d;
      rsp_ovf_q     <= rsp_ovf_d;
      rsp_err_q     <= rsp_err_d;
      in_sel_q      <= in_sel_d;
      num1_q        <= num1_d;
      num2_q        <= num2_d;
      out_sel_q     <= out_sel_d;
    end
  end

  // ALU lines are loaded on the accept edge so they are live throughout ISSUE.
  always_comb begin
    state_d       = state_q;
    clr_d         = clr_q;
    chain_d       = chain_q;
    cnt_d         = cnt_q;
    have_result_d = have_result_q;
    rsp_data_d    = rsp_data_q;
    rsp_ovf_d     = rsp_ovf_q;
    rsp_err_d     = rsp_err_q;
    in_sel_d      = in_sel_q;
    num1_d        = num1_q;
    num2_d        = num2_q;
    out_sel_d     = out_sel_q;

    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          if (chain_req && !dec_is_clear && !have_result_q) begin
            rsp_data_d = '0;
            rsp_ovf_d  = 1'b0;
            rsp_err_d  = 1'b1;
            state_d    = RESP;
          end else begin
            clr_d     = dec_is_clear;
            chain_d   = chain_req && !dec_is_clear;
            rsp_err_d = 1'b0;
            out_sel_d = dec_out_sel;
            if (dec_is_clear) begin
              in_sel_d      = IN_SEL_RESET;
              num1_d        = '0;
              num2_d        = '0;
              have_result_d = 1'b0;
            end else begin
              in_sel_d = (chain_req) ? IN_SEL_PERSIST : IN_SEL_LOAD;
              num1_d   = cmd_a;
              num2_d   = cmd_b;
            end
            state_d = ISSUE;
          end
        end
      end

      // After a persist issue, operand A is refreshed with the previous result
      // so that the idle re-load leaves the ALU state unchanged.
      ISSUE: begin
        in_sel_d = IN_SEL_LOAD;
        if (chain_q) begin
          num1_d = rsp_data_q;
        end
        cnt_d   = 3'(ALU_LATENCY - 1);
        state_d = WAIT;
      end

      WAIT: begin
        if (cnt_q == 3'd0) begin
          if (clr_q) begin
            rsp_data_d = '0;
            rsp_ovf_d  = 1'b0;
          end else begin
            rsp_data_d    = alu_result;
            rsp_ovf_d     = alu_ovf;
            have_result_d = 1'b1;
          end
          rsp_err_d = 1'b0;
          state_d   = RESP;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end

      RESP: begin
        if (rsp_ready) begin
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  assign cmd_ready   = (state_q == IDLE);
  assign rsp_valid   = (state_q == RESP);
  assign rsp_data    = rsp_data_q;
  assign rsp_ovf     = rsp_ovf_q;
  assign rsp_err     = rsp_err_q;
  assign alu_in_sel  = in_sel_q;
  assign alu_num1    = num1_q;
  assign alu_num2    = num2_q;
  assign alu_out_sel = out_sel_q;

endmodule
